// File: rtl/eth_wb_pkg.sv
// eth_wb_pkg: register map, reset values, FSM states and interrupt bits shared by the
// Ethernet MAC Wishbone slave and its testbench-visible configuration.
package eth_wb_pkg;

    localparam logic [9:0] ADR_MODER      = 10'h000;
    localparam logic [9:0] ADR_INT_SOURCE = 10'h001;
    localparam logic [9:0] ADR_INT_MASK   = 10'h002;
    localparam logic [9:0] ADR_IPGT       = 10'h003;
    localparam logic [9:0] ADR_TX_BD_NUM  = 10'h008;

    localparam logic [31:0] RST_MODER     = 32'h0000_A000;
    localparam logic [6:0]  RST_IPGT      = 7'h12;
    localparam logic [7:0]  RST_TX_BD_NUM = 8'h40;
    localparam logic [31:0] TX_BD_NUM_MAX = 32'h0000_0080;

    localparam int INT_TXB  = 0;
    localparam int INT_TXE  = 1;
    localparam int INT_RXB  = 2;
    localparam int INT_RXE  = 3;
    localparam int INT_BUSY = 4;
    localparam int INT_TXC  = 5;
    localparam int INT_RXC  = 6;
    localparam int INT_W    = INT_RXC + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_TURN
    } state_t;

    function automatic logic is_reg_adr(input logic [9:0] a);
        return a inside {ADR_MODER, ADR_INT_SOURCE, ADR_INT_MASK, ADR_IPGT, ADR_TX_BD_NUM};
    endfunction

    function automatic logic is_bd_adr(input logic [9:0] a);
        return a[9:8] == 2'b01;
    endfunction

endpackage

// File: rtl/eth_bd_ram.sv
// eth_bd_ram: 256x32 synchronous single-port buffer-descriptor RAM with byte write enables.
module eth_bd_ram (
    input  logic        i_clk,
    input  logic        i_en,
    input  logic [3:0]  i_we,
    input  logic [7:0]  i_adr,
    input  logic [31:0] i_din,
    output logic [31:0] o_dout
);

    logic [31:0] r_mem [256];
    logic [31:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_en)
            r_q <= r_mem[i_adr];
        for (int i = 0; i < 4; i++)
            if (i_we[i])
                r_mem[i_adr][8*i +: 8] <= i_din[8*i +: 8];
    end

    assign o_dout = r_q;

endmodule

// File: rtl/eth_wb_slave_regs.sv
// eth_wb_slave_regs: Wishbone classic slave for the MAC control/status registers and BD RAM.
// Define ETH_WB_ERR_EN to terminate illegal accesses with wb_err_o instead of a silent ack.
module eth_wb_slave_regs
    import eth_wb_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [9:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    input  logic [INT_W-1:0]  int_set_i,
    output logic              int_o,
    output logic [31:0]       r_moder_o,
    output logic [7:0]        r_tx_bd_num_o
);

    state_t r_state, w_next;
    logic [2:0]       r_cnt;
    logic [9:0]       r_adr;
    logic [31:0]      r_dat;
    logic [3:0]       r_sel;
    logic             r_we;
    logic [31:0]      r_moder;
    logic [INT_W-1:0] r_int_src, r_int_mask;
    logic [6:0]       r_ipgt;
    logic [7:0]       r_tx_bd_num;
    logic             r_int;

    logic             w_bd, w_err, w_resp, w_commit;
    logic [9:0]       w_ram_adr;
    logic [3:0]       w_ram_we;
    logic [31:0]      w_ram_q, w_reg_dat, w_rdat;
    logic [INT_W-1:0] w_w1c;

    assign w_bd     = is_bd_adr(r_adr);
    assign w_err    = !(w_bd || (is_reg_adr(r_adr) && r_sel == 4'hF));
    assign w_resp   = r_state == ST_RESP && wb_cyc_i;
    assign w_commit = w_resp && r_we && !w_err && !wb_rst_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = (wb_cyc_i && wb_stb_i) ? ((WAIT_STATES == 0) ? ST_RESP : ST_WAIT) : ST_IDLE;
            ST_WAIT: w_next = !wb_cyc_i ? ST_IDLE : (r_cnt == 3'd0) ? ST_RESP : ST_WAIT;
            ST_RESP: w_next = wb_cyc_i ? ST_TURN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE) begin
                r_adr <= wb_adr_i;
                r_dat <= wb_dat_i;
                r_sel <= wb_sel_i;
                r_we  <= wb_we_i;
                r_cnt <= 3'(WAIT_STATES - 1);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // A set pulse on the commit edge overrides a coincident write-1-to-clear.
    assign w_w1c = (w_commit && r_adr == ADR_INT_SOURCE) ? r_dat[INT_W-1:0] : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_moder     <= RST_MODER;
            r_int_src   <= '0;
            r_int_mask  <= '0;
            r_ipgt      <= RST_IPGT;
            r_tx_bd_num <= RST_TX_BD_NUM;
            r_int       <= 1'b0;
        end else begin
            r_int_src <= (r_int_src & ~w_w1c) | int_set_i;
            r_int     <= |(r_int_src & r_int_mask);
            if (w_commit && r_adr == ADR_MODER)
                r_moder <= r_dat;
            if (w_commit && r_adr == ADR_INT_MASK)
                r_int_mask <= r_dat[INT_W-1:0];
            if (w_commit && r_adr == ADR_IPGT)
                r_ipgt <= r_dat[6:0];
            if (w_commit && r_adr == ADR_TX_BD_NUM && r_dat <= TX_BD_NUM_MAX)
                r_tx_bd_num <= r_dat[7:0];
        end
    end

    // The RAM read is launched on the edge entering RESP; in IDLE the address is still on the bus.
    assign w_ram_adr = (r_state == ST_IDLE) ? wb_adr_i : r_adr;
    assign w_ram_we  = (w_commit && w_bd) ? r_sel : 4'd0;

    eth_bd_ram u_bd_ram (
        .i_clk  (wb_clk_i),
        .i_en   (w_next == ST_RESP),
        .i_we   (w_ram_we),
        .i_adr  (w_ram_adr[7:0]),
        .i_din  (r_dat),
        .o_dout (w_ram_q)
    );

    assign w_reg_dat = (r_adr == ADR_MODER)      ? r_moder :
                       (r_adr == ADR_INT_SOURCE) ? 32'(r_int_src) :
                       (r_adr == ADR_INT_MASK)   ? 32'(r_int_mask) :
                       (r_adr == ADR_IPGT)       ? 32'(r_ipgt) :
                       (r_adr == ADR_TX_BD_NUM)  ? 32'(r_tx_bd_num) : 32'd0;
    assign w_rdat    = w_err ? 32'd0 : w_bd ? w_ram_q : w_reg_dat;

`ifdef ETH_WB_ERR_EN
    assign wb_ack_o = w_resp && !w_err;
    assign wb_err_o = w_resp && w_err;
`else
    assign wb_ack_o = w_resp;
    assign wb_err_o = 1'b0;
`endif

    assign wb_dat_o      = wb_ack_o ? w_rdat : 32'd0;
    assign int_o         = r_int;
    assign r_moder_o     = r_moder;
    assign r_tx_bd_num_o = r_tx_bd_num;

endmodule
